// File: rtl/reg_wb_ctrl.sv
// Register-file write-port controller: merges pipeline writeback with a 2-entry long-latency result buffer.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module reg_wb_ctrl #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_en,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  input  logic        lu_issue_valid,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_res_valid,
  output logic        lu_res_ready,
  input  logic [4:0]  lu_res_rd,
  input  logic [31:0] lu_res_data,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  output logic [31:0] busy_mask,
  output logic        pipe_hold,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
    $error("reg_wb_ctrl: STARVE_LIMIT must be in 1..255");
  end

  logic [4:0]  fifo_rd   [2];
  logic [31:0] fifo_data [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  logic        pipe_active;
  logic        fifo_empty;
  logic        enq;
  logic        deq;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic [31:0] busy_next;

  assign fifo_empty   = (count == 2'd0);
  assign tail         = head ^ count[0];
  assign head_rd      = fifo_rd[head];
  assign head_data    = fifo_data[head];
  assign pipe_active  = pipe_wb_en & (pipe_rd != 5'd0);
  assign lu_res_ready = (count != 2'd2) & ~rst;
  // rd=0 results are handshaken but never stored
  assign enq          = lu_res_valid & lu_res_ready & (lu_res_rd != 5'd0);
  assign deq          = ~pipe_active & ~fifo_empty;

  assign dec_stall = busy_mask[dec_rs1] | busy_mask[dec_rs2] | busy_mask[dec_rd];

  // Clear for the retiring head is applied first so a same-cycle issue wins.
  always_comb begin
    busy_next = busy_mask;
    if (deq)
      busy_next[head_rd] = 1'b0;
    if (lu_issue_valid && lu_issue_rd != 5'd0)
      busy_next[lu_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[tail]   <= lu_res_rd;
      fifo_data[tail] <= lu_res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= 1'b0;
      count     <= '0;
      rf_we     <= 1'b0;
      rf_a3     <= '0;
      rf_wd3    <= '0;
      busy_mask <= '0;
    end else begin
      if (deq)
        head <= ~head;
      count <= count + {1'b0, enq} - {1'b0, deq};
      busy_mask <= busy_next;
      if (pipe_active) begin
        rf_we  <= 1'b1;
        rf_a3  <= pipe_rd;
        rf_wd3 <= pipe_wd;
      end else if (deq) begin
        rf_we  <= 1'b1;
        rf_a3  <= head_rd;
        rf_wd3 <= head_data;
      end else begin
        rf_we  <= 1'b0;
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      if (deq || fifo_empty)
        starve_cnt <= '0;
      else if (starve_cnt != 8'hFF)
        starve_cnt <= starve_cnt + 8'd1;

      if (deq)
        pipe_hold <= 1'b0;
      else if (!fifo_empty && starve_cnt >= 8'(STARVE_LIMIT))
        pipe_hold <= 1'b1;
    end
  end
`else
  assign pipe_hold = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: stimulus pushes expected register-file writes, a negedge monitor checks them.
module tb_reg_wb_ctrl;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wb_en = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_wd = '0;
  logic        lu_issue_valid = 1'b0;
  logic [4:0]  lu_issue_rd = '0;
  logic        lu_res_valid = 1'b0;
  logic        lu_res_ready;
  logic [4:0]  lu_res_rd = '0;
  logic [31:0] lu_res_data = '0;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic [4:0]  dec_rd = '0;
  logic        dec_stall;
  logic [31:0] busy_mask;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  reg_wb_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .lu_issue_valid(lu_issue_valid), .lu_issue_rd(lu_issue_rd),
    .lu_res_valid(lu_res_valid), .lu_res_ready(lu_res_ready),
    .lu_res_rd(lu_res_rd), .lu_res_data(lu_res_data),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
    .busy_mask(busy_mask), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [4:0]  a3;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  // Every cycle after reset either the scheduled write appears or the port is idle.
  always @(negedge clk) begin
    if (!rst && cyc > 2) begin
      checks++;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        if (rf_we !== 1'b1 || rf_a3 !== e.a3 || rf_wd3 !== e.wd) begin
          errors++;
          $display("FAIL wb_write cyc=%0d: got we=%b a3=%0d wd=%h, expected we=1 a3=%0d wd=%h",
                   cyc, rf_we, rf_a3, rf_wd3, e.a3, e.wd);
        end
      end else if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL wb_idle cyc=%0d: got we=%b a3=%0d wd=%h, expected we=0",
                 cyc, rf_we, rf_a3, rf_wd3);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    q.push_back('{cyc + 1, a, d});
  endtask

  task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] wd);
    pipe_wb_en = en;
    pipe_rd    = rd;
    pipe_wd    = wd;
  endtask

  task automatic res(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_res_valid = v;
    lu_res_rd    = rd;
    lu_res_data  = d;
  endtask

  initial begin
    // Reset held for two edges with random inputs
    for (int i = 0; i < 2; i++) begin
      pipe($urandom_range(0, 1), 5'($urandom), $urandom);
      res($urandom_range(0, 1), 5'($urandom), $urandom);
      lu_issue_valid = $urandom_range(0, 1);
      lu_issue_rd    = 5'($urandom);
      #1;
      chk("reset_ready", {31'd0, lu_res_ready}, 32'd0);
      tick();
    end
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_a3", {27'd0, rf_a3}, 32'd0);
    chk("reset_wd3", rf_wd3, 32'd0);
    chk("reset_busy", busy_mask, 32'd0);
    chk("reset_hold", {31'd0, pipe_hold}, 32'd0);
    rst = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    res(1'b0, 5'd0, 32'd0);
    lu_issue_valid = 1'b0;
    lu_issue_rd    = 5'd0;
    #1;
    chk("ready_after_reset", {31'd0, lu_res_ready}, 32'd1);
    tick();

    // Pipeline write, then rd=0 bubble holding address/data
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    pipe(1'b1, 5'd0, 32'h0BADF00D);
    tick();
    chk("rd0_we", {31'd0, rf_we}, 32'd0);
    chk("rd0_hold_a3", {27'd0, rf_a3}, 32'd5);
    chk("rd0_hold_wd3", rf_wd3, 32'hDEADBEEF);
    pipe(1'b0, 5'd0, 32'd0);

    // Scoreboard round trip
    lu_issue_valid = 1'b1;
    lu_issue_rd    = 5'd7;
    tick();
    lu_issue_valid = 1'b0;
    chk("busy_set7", busy_mask, 32'h0000_0080);
    dec_rs1 = 5'd7; #1;
    chk("stall_rs1", {31'd0, dec_stall}, 32'd1);
    dec_rs1 = 5'd3; dec_rd = 5'd7; #1;
    chk("stall_rd", {31'd0, dec_stall}, 32'd1);
    dec_rd = 5'd4; #1;
    chk("no_stall", {31'd0, dec_stall}, 32'd0);
    res(1'b1, 5'd7, 32'h12345678);
    tick();
    res(1'b0, 5'd0, 32'd0);
    chk("no_bypass_we", {31'd0, rf_we}, 32'd0);
    chk("busy_still7", busy_mask, 32'h0000_0080);
    expect_wr(5'd7, 32'h12345678);
    tick();
    chk("busy_clear7", busy_mask, 32'd0);

    // Full buffer with pipeline writing every cycle
    pipe(1'b1, 5'd1, 32'hA1);
    res(1'b1, 5'd10, 32'h100);
    chk("full_ready_a", {31'd0, lu_res_ready}, 32'd1);
    expect_wr(5'd1, 32'hA1);
    tick();
    pipe(1'b1, 5'd2, 32'hA2);
    res(1'b1, 5'd11, 32'h101);
    chk("full_ready_b", {31'd0, lu_res_ready}, 32'd1);
    expect_wr(5'd2, 32'hA2);
    tick();
    pipe(1'b1, 5'd3, 32'hA3);
    res(1'b1, 5'd12, 32'h102);
    chk("full_ready_c", {31'd0, lu_res_ready}, 32'd0);
    expect_wr(5'd3, 32'hA3);
    tick();
    pipe(1'b0, 5'd0, 32'd0);
    chk("full_ready_d", {31'd0, lu_res_ready}, 32'd0);
    expect_wr(5'd10, 32'h100);
    tick();
    chk("drain_ready", {31'd0, lu_res_ready}, 32'd1);
    expect_wr(5'd11, 32'h101);
    tick();
    res(1'b0, 5'd0, 32'd0);
    expect_wr(5'd12, 32'h102);
    tick();
    tick();

    // Discarded rd=0 result and rd=0 issue
    res(1'b1, 5'd0, 32'h5555_5555);
    lu_issue_valid = 1'b1;
    lu_issue_rd    = 5'd0;
    tick();
    res(1'b0, 5'd0, 32'd0);
    lu_issue_valid = 1'b0;
    tick();
    chk("rd0_discard_busy", busy_mask, 32'd0);

    // Set beats clear on the same register
    lu_issue_valid = 1'b1;
    lu_issue_rd    = 5'd9;
    tick();
    lu_issue_valid = 1'b0;
    pipe(1'b1, 5'd4, 32'hB4);
    res(1'b1, 5'd9, 32'h99);
    expect_wr(5'd4, 32'hB4);
    tick();
    pipe(1'b0, 5'd0, 32'd0);
    res(1'b0, 5'd0, 32'd0);
    lu_issue_valid = 1'b1;
    lu_issue_rd    = 5'd9;
    expect_wr(5'd9, 32'h99);
    tick();
    lu_issue_valid = 1'b0;
    chk("set_beats_clear", busy_mask, 32'h0000_0200);
    res(1'b1, 5'd9, 32'h98);
    tick();
    res(1'b0, 5'd0, 32'd0);
    expect_wr(5'd9, 32'h98);
    tick();
    chk("second_retire_clear", busy_mask, 32'd0);

    // Starvation: one buffered result behind continuous pipeline writes
    pipe(1'b1, 5'd20, 32'hE0);
    res(1'b1, 5'd13, 32'hC3);
    expect_wr(5'd20, 32'hE0);
    tick();
    res(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      pipe(1'b1, 5'(20 + k), 32'(32'hE0 + k));
      expect_wr(5'(20 + k), 32'(32'hE0 + k));
      tick();
      chk($sformatf("starve_hold_%0d", k), {31'd0, pipe_hold}, {31'd0, GUARD && (k >= 5)});
    end
    pipe(1'b0, 5'd0, 32'd0);
    expect_wr(5'd13, 32'hC3);
    tick();
    chk("starve_release", {31'd0, pipe_hold}, 32'd0);

    tick();
    tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_ctrl.md
# reg_wb_ctrl

Write-port controller for the integer register file. It merges the in-order writeback stream from the MEM/WB pipeline register with out-of-band results from long-latency units (divider, non-blocking loads) through a 2-entry result buffer. It drives the register file's single write port from registered outputs and keeps a busy scoreboard of destinations still owed by long-latency units, so decode can interlock.

## Interface
- `STARVE_LIMIT`, default 8: cycles a buffered result may wait before `pipe_hold` is raised. Range 1..255. Used only when `WB_STARVE_GUARD_EN` is defined.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `pipe_wb_en` in 1: pipeline writeback valid this cycle. There is no backpressure; the controller must accept it.
- `pipe_rd` in 5: pipeline destination register.
- `pipe_wd` in 32: pipeline write data.
- `lu_issue_valid` in 1: a long-latency op issued this cycle.
- `lu_issue_rd` in 5: destination of the issued op.
- `lu_res_valid` in 1: long-latency result offered.
- `lu_res_ready` out 1: buffer can accept a result.
- `lu_res_rd` in 5: result destination.
- `lu_res_data` in 32: result data.
- `dec_rs1`, `dec_rs2`, `dec_rd` in 5 each: decode-stage register indices.
- `dec_stall` out 1: combinational. Equals `busy_mask[dec_rs1] | busy_mask[dec_rs2] | busy_mask[dec_rd]`.
- `busy_mask` out 32: scoreboard. Bit 0 is constant 0.
- `pipe_hold` out 1: request that the pipeline insert a writeback bubble next cycle.
- `rf_we` out 1: register-file write enable.
- `rf_a3` out 5: write address.
- `rf_wd3` out 32: write data.

## Operation
- Each cycle at most one write is selected, with priority: pipeline first, then the FIFO head. The choice is registered into `rf_we`/`rf_a3`/`rf_wd3`.
- The pipeline slot counts as idle when `pipe_wb_en=0` or `pipe_rd=0`. An idle slot selects the FIFO head if the FIFO is non-empty. Otherwise the next value is `rf_we=0`, and `rf_a3`/`rf_wd3` hold their previous values.
- FIFO: 2 entries, in order, each holding {rd, data}.
  - Enqueue when `lu_res_valid & lu_res_ready`.
  - `lu_res_ready = (count != 2) & ~rst`.
  - Enqueue and dequeue may happen in the same cycle.
  - A result with rd=0 is accepted and discarded, never enqueued.
- Scoreboard:
  - `lu_issue_valid` with rd≠0 sets the bit at the edge.
  - Dequeuing an entry clears its bit at the same edge that loads `rf_we=1` for it.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Issue to an already-busy rd leaves the bit set; the first retiring result clears it. Decode prevents this case via `dec_rd`.
- The controller performs no WAW checking between pipeline and buffered writes. Ordering is guaranteed by `dec_stall`.

## Timing
- Reset values: `rf_we=0`, `rf_a3=0`, `rf_wd3=0`, `busy_mask=0`, `pipe_hold=0`, FIFO empty, starvation counter 0.
- Reset asserted mid-operation discards buffered results and clears the scoreboard at that edge.
- Pipeline write latency: inputs sampled at edge N, `rf_*` valid after edge N. They are stable through the following negedge, where the register file writes.
- Long-latency result latency: enqueued at edge N, earliest write presented after edge N+1. There is no enqueue-to-output bypass.
- `busy_mask` updates one edge after issue. `dec_stall` follows `busy_mask` combinationally.
- FIFO full (count=2) and pipeline busy: `lu_res_ready=0`. The producer must hold `lu_res_valid`, `lu_res_rd` and `lu_res_data` stable until accepted.

## Configuration
- Macro `WB_STARVE_GUARD_EN`.
- **Defined:** an 8-bit counter runs.
  - It increments each cycle the FIFO is non-empty and the head is not dequeued.
  - It resets to 0 on a head dequeue or when the FIFO is empty.
  - When the counter reaches `STARVE_LIMIT`, `pipe_hold` (registered) goes to 1 at the next edge. It stays 1 until the head dequeues, then returns to 0 on that edge.
  - If the pipeline ignores `pipe_hold`, the pipeline still wins and no data is lost. The counter saturates.
- **Not defined:** `pipe_hold` is tied to 0, and the counter is not instantiated.

## Test plan
- **Reset:** assert `rst` 2 cycles with random inputs → `rf_we=0`, `rf_a3=0`, `rf_wd3=0`, `busy_mask=0`, `pipe_hold=0`, `lu_res_ready=0` during reset and 1 after.
- **Pipeline write:** `pipe_wb_en=1`, rd=5, wd=0xDEADBEEF at edge N → after N, `rf_we=1`, `rf_a3=5`, `rf_wd3=0xDEADBEEF`. With rd=0 instead → `rf_we=0`.
- **Scoreboard round trip:** issue rd=7 → `busy_mask[7]=1`; `dec_rs1=7` → `dec_stall=1`. Then result rd=7, data 0x12345678 with the pipeline idle, enqueued at edge N → `rf_we=1`, `rf_a3=7`, `rf_wd3=0x12345678` after N+1, and `busy_mask[7]=0` at the same edge.
- **Full buffer:** pipeline writes every cycle; two results enqueued → `lu_res_ready=0`, third result held. Drop `pipe_wb_en` → heads drain in order on consecutive cycles and the third result is then accepted.
- **Set beats clear:** issue rd=9 in the same cycle the buffered rd=9 result dequeues → `busy_mask[9]` remains 1.
- **Starvation (macro on, `STARVE_LIMIT=4`):** continuous pipeline writes with one buffered result → `pipe_hold=1` after the 5th edge. Pipeline bubbles → head written and `pipe_hold=0`. With the macro off → `pipe_hold` stays 0 throughout.
